// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - RV32I ALU operation decoder with a 2-entry output FIFO
//
// Decodes RV32I instruction words into an ALU operation code, a SrcB select
// and an illegal flag. Decoded entries are queued in a 2-entry FIFO and
// drained by the ALU-side consumer.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   InValid       instruction on Instr is offered
//   Instr         RV32I instruction word
//   InReady       decoder can accept an instruction this cycle
//   OutValid      head decoded entry is presented
//   OutReady      consumer takes the head entry
//   Operation     ALU operation code of the head entry (0 when empty)
//   ALUSrc        head entry SrcB select: 1 = immediate, 0 = rs2 (0 when empty)
//   Illegal       head entry was not decodable (0 when empty)
//   IllegalCount  saturating count of accepted illegal instructions
module alu_op_decoder #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     InValid,
    input  logic [DATA_WIDTH-1:0]    Instr,
    output logic                     InReady,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     ALUSrc,
    output logic                     Illegal,
    output logic [15:0]              IllegalCount
);

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_LUI = OPCODE_LENGTH'(4'b1010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b1110);

    // Entry layout: {illegal, alu_src, operation}
    localparam int ENTRY_W = OPCODE_LENGTH + 2;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    // Register and immediate fields do not affect the ALU operation.
    logic unused_instr_bits;

    assign opcode            = Instr[6:0];
    assign funct3            = Instr[14:12];
    assign funct7            = Instr[31:25];
    assign unused_instr_bits = ^{Instr[24:15], Instr[11:7]};

    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_src;
    logic                     dec_ill;

    always_comb begin
        dec_op  = OP_AND;
        dec_src = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                dec_src = 1'b0;
                case (funct3)
                    3'b000:  dec_op = funct7[5] ? OP_SUB : OP_ADD;
                    3'b100:  dec_op = OP_XOR;
                    3'b110:  dec_op = OP_OR;
                    3'b111:  dec_op = OP_AND;
                    3'b010:  dec_op = OP_SLT;
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_ITYPE: begin
                dec_src = 1'b1;
                case (funct3)
                    3'b000:  dec_op = OP_ADD;
                    3'b010:  dec_op = OP_SLT;
                    3'b100:  dec_op = OP_XOR;
                    3'b110:  dec_op = OP_OR;
                    3'b111:  dec_op = OP_AND;
                    3'b001: begin
                        if (funct7 == F7_ZERO) dec_op  = OP_SLL;
                        else                   dec_ill = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == F7_ZERO)     dec_op  = OP_SRL;
                        else if (funct7 == F7_ALT) dec_op  = OP_SRA;
                        else                       dec_ill = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_op  = OP_LUI;
                dec_src = 1'b1;
            end
            OPC_LOAD, OPC_STORE: begin
                dec_op  = OP_ADD;
                dec_src = 1'b1;
            end
            OPC_BRANCH: begin
                dec_src = 1'b0;
                case (funct3)
                    3'b000:  dec_op = OP_EQ;
                    3'b100:  dec_op = OP_SLT;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal entries carry a neutral payload so the ALU sees nothing stale.
        if (dec_ill) begin
            dec_op  = OP_AND;
            dec_src = 1'b0;
        end
    end

    logic [1:0]         count_q, count_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [15:0]        illegal_count_q, illegal_count_d;
    logic [ENTRY_W-1:0] entry_q [2];
    logic [ENTRY_W-1:0] entry_d [2];

    logic push;
    logic pop;

    // Handshakes are derived from registered occupancy only, so a pop in the
    // same cycle never frees a slot for a push when the FIFO is full.
    assign InReady  = (count_q < 2'd2);
    assign OutValid = (count_q != 2'd0);
    assign push     = InValid & InReady;
    assign pop      = OutValid & OutReady;

    always_comb begin
        count_d         = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d        = wr_ptr_q ^ push;
        rd_ptr_d        = rd_ptr_q ^ pop;
        illegal_count_d = illegal_count_q;
        if (push && dec_ill && (illegal_count_q != 16'hFFFF)) begin
            illegal_count_d = illegal_count_q + 16'd1;
        end
        entry_d[0] = entry_q[0];
        entry_d[1] = entry_q[1];
        if (push) begin
            entry_d[wr_ptr_q] = {dec_ill, dec_src, dec_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q         <= 2'd0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            illegal_count_q <= 16'd0;
        end else begin
            count_q         <= count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    // Payload storage needs no reset: it is only observed while count_q != 0.
    always_ff @(posedge clk) begin
        entry_q[0] <= entry_d[0];
        entry_q[1] <= entry_d[1];
    end

    logic [ENTRY_W-1:0] head;

    assign head         = entry_q[rd_ptr_q];
    assign Operation    = OutValid ? head[OPCODE_LENGTH-1:0] : '0;
    assign ALUSrc       = OutValid & head[OPCODE_LENGTH];
    assign Illegal      = OutValid & head[OPCODE_LENGTH+1];
    assign IllegalCount = illegal_count_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// tb/tb_alu_op_decoder.sv - self-checking bench for alu_op_decoder
module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        InValid = 1'b0;
    logic [31:0] Instr = 32'd0;
    logic        InReady;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [3:0]  Operation;
    logic        ALUSrc;
    logic        Illegal;
    logic [15:0] IllegalCount;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_op_decoder #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .InValid      (InValid),
        .Instr        (Instr),
        .InReady      (InReady),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .Operation    (Operation),
        .ALUSrc       (ALUSrc),
        .Illegal      (Illegal),
        .IllegalCount (IllegalCount)
    );

    typedef struct packed {
        logic [3:0] op;
        logic       src;
        logic       ill;
    } entry_t;

    entry_t      mq[$];
    int unsigned m_illegal = 0;

    function automatic entry_t mk(input logic [3:0] op, input logic src);
        entry_t e;
        e.op = op; e.src = src; e.ill = 1'b0;
        return e;
    endfunction

    // Reference decode straight from the instruction-set table.
    function automatic entry_t ref_decode(input logic [31:0] w);
        entry_t     bad;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        bad.op = 4'd0; bad.src = 1'b0; bad.ill = 1'b1;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        if (opc == 7'h33) begin
            if (f3 == 3'd0) return mk(f7[5] ? 4'h2 : 4'h4, 1'b0);
            if (f3 == 3'd4) return mk(4'h1, 1'b0);
            if (f3 == 3'd6) return mk(4'h3, 1'b0);
            if (f3 == 3'd7) return mk(4'h0, 1'b0);
            if (f3 == 3'd2) return mk(4'hE, 1'b0);
            return bad;
        end
        if (opc == 7'h13) begin
            if (f3 == 3'd0) return mk(4'h4, 1'b1);
            if (f3 == 3'd2) return mk(4'hE, 1'b1);
            if (f3 == 3'd4) return mk(4'h1, 1'b1);
            if (f3 == 3'd6) return mk(4'h3, 1'b1);
            if (f3 == 3'd7) return mk(4'h0, 1'b1);
            if (f3 == 3'd1 && f7 == 7'h00) return mk(4'h9, 1'b1);
            if (f3 == 3'd5 && f7 == 7'h00) return mk(4'hC, 1'b1);
            if (f3 == 3'd5 && f7 == 7'h20) return mk(4'h7, 1'b1);
            return bad;
        end
        if (opc == 7'h37) return mk(4'hA, 1'b1);
        if (opc == 7'h03 || opc == 7'h23) return mk(4'h4, 1'b1);
        if (opc == 7'h63) begin
            if (f3 == 3'd0) return mk(4'h8, 1'b0);
            if (f3 == 3'd4) return mk(4'hE, 1'b0);
            return bad;
        end
        return bad;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One rising edge; the model applies the same transfer rules at that edge.
    task automatic tick();
        bit     do_push;
        bit     do_pop;
        entry_t e;
        do_push = InValid && (mq.size() < 2);
        do_pop  = OutReady && (mq.size() != 0);
        e = ref_decode(Instr);
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back(e);
            if (e.ill && m_illegal < 16'hFFFF) m_illegal++;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        entry_t h;
        h = '0;
        if (mq.size() != 0) h = mq[0];
        chk({tag, ".in_ready"},  32'(InReady),      32'(mq.size() < 2));
        chk({tag, ".out_valid"}, 32'(OutValid),     32'(mq.size() != 0));
        chk({tag, ".operation"}, 32'(Operation),    32'(h.op));
        chk({tag, ".alu_src"},   32'(ALUSrc),       32'(h.src));
        chk({tag, ".illegal"},   32'(Illegal),      32'(h.ill));
        chk({tag, ".ill_count"}, 32'(IllegalCount), m_illegal);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  opcs [7];
        opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h37; opcs[3] = 7'h03;
        opcs[4] = 7'h23; opcs[5] = 7'h63; opcs[6] = 7'($urandom);
        w = $urandom;
        w[6:0] = opcs[$urandom_range(0, 6)];
        case ($urandom_range(0, 2))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        mq.delete(); m_illegal = 0;
        check_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        // No push on the first edge after reset release with InValid low
        tick();
        check_all("post_reset_idle");

        // ADD x1,x2,x3 with OutReady high, one-cycle latency
        OutReady = 1'b1; InValid = 1'b1; Instr = 32'h003100B3;
        tick();
        check_all("add");
        chk("add.op_const", 32'(Operation), 32'h4);
        InValid = 1'b0;
        tick();
        check_all("add_drain");

        // SRAI then SUB with OutReady low fills the FIFO
        OutReady = 1'b0; InValid = 1'b1; Instr = 32'h40315093;
        tick();
        Instr = 32'h403100B3;
        tick();
        check_all("full");
        chk("full.in_ready_const", 32'(InReady), 32'h0);
        InValid = 1'b0; OutReady = 1'b1;
        tick();
        check_all("order_second");
        chk("order_second.op_const", 32'(Operation), 32'h2);
        tick();
        check_all("order_empty");

        // Full FIFO: push offered with a pop, only the pop happens
        OutReady = 1'b0; InValid = 1'b1; Instr = 32'h003100B3;
        tick();
        Instr = 32'h0031F0B3;
        tick();
        Instr = 32'h00312093;
        OutReady = 1'b1;
        tick();
        check_all("full_pop_no_push");

        // count=1: simultaneous LUI push and pop
        Instr = 32'h000120B7;
        tick();
        check_all("lui_pushpop");
        chk("lui_pushpop.op_const", 32'(Operation), 32'hA);
        InValid = 1'b0;
        tick();
        check_all("lui_drain");

        // Illegal: all-ones word and BNE
        InValid = 1'b1; Instr = 32'hFFFFFFFF;
        tick();
        check_all("ill_ones");
        Instr = 32'h00209463;
        tick();
        check_all("ill_bne");
        InValid = 1'b0;
        tick();
        chk("ill_count_two", 32'(IllegalCount), 32'd2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            InValid  = 1'($urandom);
            OutReady = ($urandom_range(0, 3) != 0);
            Instr    = rand_instr();
            tick();
            check_all("rand");
        end

        // Drive illegal words until the counter saturates
        InValid = 1'b1; OutReady = 1'b1; Instr = 32'hFFFFFFFF;
        for (int i = 0; i < 70000; i++) begin
            if (m_illegal == 16'hFFFF && i > 8) break;
            tick();
        end
        for (int i = 0; i < 4; i++) tick();
        check_all("saturate");
        chk("saturate.const", 32'(IllegalCount), 32'hFFFF);

        // Asynchronous reset with two entries pending
        OutReady = 1'b0; InValid = 1'b1; Instr = 32'h003100B3;
        tick();
        tick();
        check_all("pre_reset_full");
        InValid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        mq.delete(); m_illegal = 0;
        chk("async_rst.out_valid", 32'(OutValid), 32'h0);
        chk("async_rst.in_ready",  32'(InReady),  32'h1);
        chk("async_rst.ill_count", 32'(IllegalCount), 32'h0);
        check_all("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        check_all("after_async_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_op_decoder.md
ALU_OP_DECODER -- requirements
Module: alu_op_decoder

Interface
- REQ-001: The module SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word width.
- REQ-002: The module SHALL have parameter OPCODE_LENGTH, default 4, meaning the ALU Operation code width.
- REQ-003: clk  input  1  single clock; all state updates on the rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous and active-low.
- REQ-005: InValid  input  1  the instruction on Instr is offered.
- REQ-006: Instr  input  DATA_WIDTH  RV32I instruction word.
- REQ-007: InReady  output  1  the decoder can accept an instruction this cycle.
- REQ-008: OutValid  output  1  the head decoded entry is presented.
- REQ-009: OutReady  input  1  the ALU-side consumer takes the head entry.
- REQ-010: Operation  output  OPCODE_LENGTH  ALU operation code of the head entry.
- REQ-011: ALUSrc  output  1  SrcB comes from the immediate (1) or from rs2 (0).
- REQ-012: Illegal  output  1  the head entry was not decodable.
- REQ-013: IllegalCount  output  16  saturating count of illegal instructions accepted.

Function
- REQ-014: An input transfer SHALL occur when InValid and InReady are both high; an output transfer SHALL occur when OutValid and OutReady are both high.
- REQ-015: Decoded entries SHALL be held in a 2-entry FIFO, with a 2-bit occupancy count (0..2), a 1-bit write pointer and a 1-bit read pointer.
- REQ-016: InReady SHALL equal (count < 2), and OutValid SHALL equal (count != 0); both are driven from registered state only.
- REQ-017: Latency SHALL be 1 cycle: an instruction accepted at edge N SHALL be presented with OutValid=1 after edge N when the FIFO was empty.
- REQ-018: On a simultaneous input and output transfer, count SHALL be unchanged, both pointers SHALL advance, and FIFO order SHALL be preserved.
- REQ-019: When count=2, no input transfer SHALL occur, even if an output transfer happens in the same cycle.
- REQ-020: When count=0, Operation, ALUSrc and Illegal SHALL read 0.
- REQ-021: Decoding for opcode 0110011 (R-type), with ALUSrc=0: funct3 000 with funct7[5]=0 gives ADD 0100; 000 with funct7[5]=1 gives SUB 0010; 100 gives XOR 0001; 110 gives OR 0011; 111 gives AND 0000; 010 gives SLT 1110; any other combination is illegal.
- REQ-022: Decoding for opcode 0010011 (I-type ALU), with ALUSrc=1: funct3 000 gives 0100; 010 gives 1110; 100 gives 0001; 110 gives 0011; 111 gives 0000; 001 with funct7=0000000 gives SLLI 1001; 101 with funct7=0000000 gives SRLI 1100; 101 with funct7=0100000 gives SRAI 0111; any other funct7 on 001 or 101 is illegal.
- REQ-023: Opcode 0110111 (LUI) SHALL decode to 1010 with ALUSrc=1.
- REQ-024: Opcodes 0000011 (load) and 0100011 (store) SHALL decode to ADD 0100 with ALUSrc=1.
- REQ-025: Opcode 1100011 (branch) SHALL decode with ALUSrc=0: funct3 000 gives Equal 1000; funct3 100 gives 1110; any other funct3 is illegal.
- REQ-026: Any other opcode SHALL be illegal.
- REQ-027: An illegal entry SHALL be stored with Operation=0000, ALUSrc=0 and Illegal=1.
- REQ-028: IllegalCount SHALL increment by 1 on each accepted illegal instruction and SHALL hold at 16'hFFFF without wrapping.

Reset
- REQ-029: While rst_n=0, count, both pointers and IllegalCount SHALL be 0, and InReady SHALL be 1; the FIFO storage contents are don't-care.
- REQ-030: Assertion of rst_n mid-operation SHALL immediately force OutValid=0 and discard all pending entries.
- REQ-031: No input transfer SHALL occur on the first rising edge after rst_n deasserts unless InValid is high at that edge.

Verification
- REQ-032: Scenario: OutReady=1, push ADD x1,x2,x3 (0x003100B3) -> next cycle OutValid=1, Operation=0100, ALUSrc=0, Illegal=0.
- REQ-033: Scenario: push SRAI x1,x2,3 (0x40315093) then SUB (0x403100B3) with OutReady=0 -> count=2, InReady=0; then assert OutReady -> outputs 0111/ALUSrc=1, then 0010/ALUSrc=0, in that order.
- REQ-034: Scenario: FIFO full, InValid=1 and OutReady=1 in the same cycle -> one entry popped, no push, count=1.
- REQ-035: Scenario: count=1, simultaneous push of LUI (0x000120B7) and pop -> count stays 1, next head is Operation=1010, ALUSrc=1.
- REQ-036: Scenario: push 0xFFFFFFFF and a BNE (funct3 001) -> each yields Illegal=1, Operation=0000, IllegalCount=2; with IllegalCount preloaded near 16'hFFFF -> it saturates at 16'hFFFF.
- REQ-037: Scenario: pull rst_n low with 2 entries pending -> OutValid=0, IllegalCount=0 and InReady=1 without waiting for a clock edge.
